// File: rtl/rand_slot_alloc.sv
//------------------------------------------------------------------------------
// Module      : rand_slot_alloc
// Description : Random-replacement slot allocator for a BS-entry resource pool.
//               Starts each allocation at the PRNG index supplied on rnd and,
//               if that slot is taken, probes linearly upward (wrapping) until
//               it finds a free one. One allocation is in flight at a time
//               (req/gnt handshake) and one release is accepted per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk         in   1      clock
//   rst         in   1      reset, asynchronous, active-high
//   rnd         in   IDX_W  random start index, sampled when a request is taken
//   alloc_req   in   1      allocation request (level)
//   alloc_gnt   out  1      one-cycle pulse, alloc_idx valid and slot now owned
//   alloc_fail  out  1      one-cycle pulse, pool full, nothing allocated
//   alloc_idx   out  IDX_W  granted slot, held until the next grant
//   free_vld    in   1      release strobe
//   free_idx    in   IDX_W  slot to release
//   occ         out  BS     registered occupancy vector (1 = allocated)
//   full        out  1      all slots allocated
//   probe_cnt   out  16     count of probe cycles that hit an occupied slot
//
// Build option
//   RAND_ALLOC_STATS_EN : when defined, probe_cnt is a saturating 16-bit
//                         collision counter; otherwise it is tied to zero.
//------------------------------------------------------------------------------
`default_nettype none

module rand_slot_alloc #(
  parameter  int BS    = 16,
  localparam int IDX_W = $clog2(BS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rnd,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic             alloc_fail,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_vld,
  input  logic [IDX_W-1:0] free_idx,
  output logic [BS-1:0]    occ,
  output logic             full,
  output logic [15:0]      probe_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_PROBE = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_step;
  logic [BS-1:0]    r_occ;
  logic [BS-1:0]    w_occ_next;

  logic w_load_ptr;
  logic w_adv_ptr;
  logic w_grant;
  logic w_fail;
  logic w_hit;

  assign occ   = r_occ;
  assign full  = &r_occ;
  assign w_hit = r_occ[r_ptr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (alloc_req && !full) w_state_next = S_PROBE;
      S_PROBE: if (!w_hit)             w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_load_ptr = 1'b0;
    w_adv_ptr  = 1'b0;
    w_grant    = 1'b0;
    w_fail     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (alloc_req) begin
          if (full) w_fail     = 1'b1;
          else      w_load_ptr = 1'b1;
        end
      end
      S_PROBE: begin
        if (w_hit) w_adv_ptr = 1'b1;
        else       w_grant   = 1'b1;
      end
      default: ;
    endcase
  end

  // Release is applied first so that a grant of the same slot on the same
  // edge wins and leaves the slot allocated.
  always_comb begin
    w_occ_next = r_occ;
    if (free_vld) w_occ_next[free_idx] = 1'b0;
    if (w_grant)  w_occ_next[r_ptr]    = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_step     <= '0;
      r_occ      <= '0;
      alloc_idx  <= '0;
      alloc_gnt  <= 1'b0;
      alloc_fail <= 1'b0;
    end else begin
      alloc_gnt  <= w_grant;
      alloc_fail <= w_fail;
      r_occ      <= w_occ_next;
      if (w_load_ptr) begin
        r_ptr  <= rnd;
        r_step <= '0;
      end else if (w_adv_ptr) begin
        // Natural IDX_W-bit rollover gives the modulo-BS wrap.
        r_ptr  <= r_ptr + IDX_W'(1);
        r_step <= r_step + IDX_W'(1);
      end
      if (w_grant) alloc_idx <= r_ptr;
    end
  end

  // The pool was not full at entry and releases only clear bits, so the last
  // possible probe must land on a free slot.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(r_state == S_PROBE && w_hit && r_step == IDX_W'(BS - 1)));
    end
  end

`ifdef RAND_ALLOC_STATS_EN
  logic [15:0] r_probe_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_probe_cnt <= '0;
    end else if (w_adv_ptr && r_probe_cnt != 16'hFFFF) begin
      r_probe_cnt <= r_probe_cnt + 16'd1;
    end
  end

  assign probe_cnt = r_probe_cnt;
`else
  assign probe_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rand_slot_alloc.sv
//------------------------------------------------------------------------------
// Module      : tb_rand_slot_alloc
// Description : Directed self-checking bench for rand_slot_alloc (BS = 16).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rand_slot_alloc;

  localparam int BS = 16;

`ifdef RAND_ALLOC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rnd;
  logic        alloc_req;
  logic        alloc_gnt;
  logic        alloc_fail;
  logic [3:0]  alloc_idx;
  logic        free_vld;
  logic [3:0]  free_idx;
  logic [15:0] occ;
  logic        full;
  logic [15:0] probe_cnt;

  int checks = 0;
  int errors = 0;

  rand_slot_alloc #(.BS(BS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_fail (alloc_fail),
    .alloc_idx  (alloc_idx),
    .free_vld   (free_vld),
    .free_idx   (free_idx),
    .occ        (occ),
    .full       (full),
    .probe_cnt  (probe_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    free_idx  = '0;
    rnd       = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Request with start index r; latency counts rising edges from the one that
  // samples the request to the one after which gnt/fail is seen.
  task automatic do_alloc(input logic [3:0] r, output int lat,
                          output logic got_gnt, output logic got_fail);
    rnd       = r;
    alloc_req = 1'b1;
    lat       = 0;
    got_gnt   = 1'b0;
    got_fail  = 1'b0;
    for (int i = 0; i < 40 && !got_gnt && !got_fail; i++) begin
      tick();
      lat++;
      got_gnt  = alloc_gnt;
      got_fail = alloc_fail;
    end
    alloc_req = 1'b0;
  endtask

  task automatic do_free(input logic [3:0] idx);
    free_vld = 1'b1;
    free_idx = idx;
    tick();
    free_vld = 1'b0;
  endtask

  initial begin
    int   lat;
    logic g;
    logic f;
    int   seen;

    // ---- reset state
    do_reset();
    check("rst_occ",   32'(occ),        32'h0);
    check("rst_full",  32'(full),       32'h0);
    check("rst_gnt",   32'(alloc_gnt),  32'h0);
    check("rst_fail",  32'(alloc_fail), 32'h0);
    check("rst_idx",   32'(alloc_idx),  32'h0);
    check("rst_pcnt",  32'(probe_cnt),  32'h0);

    // ---- empty pool, rnd=5
    do_alloc(4'd5, lat, g, f);
    check("t1_gnt", 32'(g),         32'h1);
    check("t1_lat", 32'(lat),       32'd2);
    check("t1_idx", 32'(alloc_idx), 32'h5);
    check("t1_occ", 32'(occ),       32'h0020);
    tick();
    check("t1_gnt_pulse", 32'(alloc_gnt), 32'h0);

    // ---- preload 5,6,7 then collide at 5
    do_alloc(4'd6, lat, g, f);
    do_alloc(4'd7, lat, g, f);
    check("t2_pre_occ", 32'(occ), 32'h00E0);
    do_alloc(4'd5, lat, g, f);
    check("t2_gnt",  32'(g),         32'h1);
    check("t2_lat",  32'(lat),       32'd5);
    check("t2_idx",  32'(alloc_idx), 32'h8);
    check("t2_occ",  32'(occ),       32'h01E0);
    check("t2_pcnt", 32'(probe_cnt), STATS ? 32'd3 : 32'd0);

    // ---- wrap-around
    do_reset();
    for (int i = 0; i < 15; i++) do_alloc(4'(i), lat, g, f);
    check("t3_pre_occ",  32'(occ),  32'h7FFF);
    check("t3_pre_full", 32'(full), 32'h0);
    do_alloc(4'd15, lat, g, f);
    check("t3a_lat",  32'(lat),       32'd2);
    check("t3a_idx",  32'(alloc_idx), 32'hF);
    check("t3a_full", 32'(full),      32'h1);
    do_free(4'd3);
    check("t3_free_occ",  32'(occ),  32'hFFF7);
    check("t3_free_full", 32'(full), 32'h0);
    do_alloc(4'd15, lat, g, f);
    check("t3b_gnt",  32'(g),         32'h1);
    check("t3b_lat",  32'(lat),       32'd6);
    check("t3b_idx",  32'(alloc_idx), 32'h3);
    check("t3b_occ",  32'(occ),       32'hFFFF);
    check("t3b_pcnt", 32'(probe_cnt), STATS ? 32'd4 : 32'd0);

    // ---- full pool
    do_alloc(4'd7, lat, g, f);
    check("t4_fail", 32'(f),   32'h1);
    check("t4_gnt",  32'(g),   32'h0);
    check("t4_lat",  32'(lat), 32'd1);
    check("t4_occ",  32'(occ), 32'hFFFF);
    tick();
    check("t4_fail_pulse", 32'(alloc_fail), 32'h0);
    check("t4_no_gnt",     32'(alloc_gnt),  32'h0);

    // full-pool request with a release on the same edge
    rnd       = 4'd0;
    alloc_req = 1'b1;
    free_vld  = 1'b1;
    free_idx  = 4'd2;
    tick();
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    check("t5_fail", 32'(alloc_fail), 32'h1);
    check("t5_gnt",  32'(alloc_gnt),  32'h0);
    check("t5_occ",  32'(occ),        32'hFFFB);

    // ---- free on the granting edge of the same slot
    do_reset();
    rnd       = 4'd9;
    alloc_req = 1'b1;
    tick();
    free_vld  = 1'b1;
    free_idx  = 4'd9;
    tick();
    free_vld  = 1'b0;
    alloc_req = 1'b0;
    check("t6_gnt", 32'(alloc_gnt), 32'h1);
    check("t6_idx", 32'(alloc_idx), 32'h9);
    check("t6_occ", 32'(occ),       32'h0200);

    // free of an already-free slot
    do_free(4'd4);
    check("t6_free_nop", 32'(occ), 32'h0200);

    // free of the probed slot while occupied: probe still advances
    rnd       = 4'd9;
    alloc_req = 1'b1;
    tick();
    free_vld  = 1'b1;
    free_idx  = 4'd9;
    tick();
    free_vld  = 1'b0;
    check("t7_no_gnt_yet", 32'(alloc_gnt), 32'h0);
    tick();
    alloc_req = 1'b0;
    check("t7_gnt",  32'(alloc_gnt), 32'h1);
    check("t7_idx",  32'(alloc_idx), 32'hA);
    check("t7_occ",  32'(occ),       32'h0400);
    check("t7_pcnt", 32'(probe_cnt), STATS ? 32'd1 : 32'd0);

    // ---- reset mid-probe
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc(4'(i), lat, g, f);
    check("t8_pre_occ", 32'(occ),       32'h00FF);
    check("t8_pre_idx", 32'(alloc_idx), 32'h7);
    rnd       = 4'd0;
    alloc_req = 1'b1;
    tick();
    tick();
    tick();
    check("t8_mid_gnt", 32'(alloc_gnt), 32'h0);
    rst       = 1'b1;
    alloc_req = 1'b0;
    #1;
    check("t8_rst_occ",  32'(occ),        32'h0);
    check("t8_rst_full", 32'(full),       32'h0);
    check("t8_rst_gnt",  32'(alloc_gnt),  32'h0);
    check("t8_rst_fail", 32'(alloc_fail), 32'h0);
    check("t8_rst_idx",  32'(alloc_idx),  32'h0);
    check("t8_rst_pcnt", 32'(probe_cnt),  32'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (alloc_gnt) seen++;
    end
    check("t8_no_gnt", 32'(seen), 32'd0);
    do_alloc(4'd0, lat, g, f);
    check("t8_gnt", 32'(g),         32'h1);
    check("t8_lat", 32'(lat),       32'd2);
    check("t8_idx", 32'(alloc_idx), 32'h0);
    check("t8_occ", 32'(occ),       32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rand_slot_alloc.md
# rand_slot_alloc

Random-replacement slot allocator that consumes the per-cycle index stream from the LFSR PRNG (its `random_number` output drives `rnd` here) and uses it to pick a free entry in a BS-entry resource pool. It keeps an occupancy vector, serves one allocation request at a time through a req/gnt handshake, and accepts one release per cycle. When the random slot is occupied, it probes linearly from the random start point, wrapping around.

## Interface
- BS, 16: number of slots. Must be a power of two, ≥2.
- IDX_W, $clog2(BS): local, not overridable. Width of all slot indices; matches the PRNG output width for the same BS.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rnd  in  IDX_W  random start index from the PRNG; sampled only when a request is accepted.
- alloc_req  in  1  allocation request, level.
- alloc_gnt  out  1  one-cycle pulse: alloc_idx is valid and the slot is now owned.
- alloc_fail  out  1  one-cycle pulse: pool full, nothing allocated.
- alloc_idx  out  IDX_W  granted slot; holds its value until the next grant.
- free_vld  in  1  release strobe.
- free_idx  in  IDX_W  slot to release.
- occ  out  BS  occupancy vector, registered; bit i = 1 means slot i is allocated.
- full  out  1  &occ, combinational from the registered occ.
- probe_cnt  out  16  collision statistics (see Configuration).

## Operation
- FSM states: IDLE, PROBE.
- IDLE, alloc_req=1, full=1: alloc_fail<=1. Stay in IDLE.
- IDLE, alloc_req=1, full=0: ptr<=rnd, step<=0, go to PROBE.
- PROBE, occ[ptr]=0:
  - occ[ptr]<=1, alloc_idx<=ptr, alloc_gnt<=1.
  - Go to IDLE.
- PROBE, occ[ptr]=1: ptr<=ptr+1, with modulo-BS wrap (BS-1 → 0). Stay in PROBE.
- Probe termination: full was 0 at entry and frees can only clear bits, so PROBE ends within BS cycles. Also, step≥BS-1 with the slot still occupied cannot occur; implementations assert on it in simulation.
- Release: free_vld=1 clears occ[free_idx] at the next edge, in any state.
  - Freeing an already-free slot has no effect and is not an error.
- alloc_req is only sampled in IDLE. The requester holds req until it sees gnt or fail, then drops req in the following cycle. If req is still high in the first IDLE cycle after a gnt, a new allocation begins.
- Same-edge conflicts, all decisions use the pre-edge registered occ:
  - Free and grant of the same slot: the set wins, and the slot ends up allocated.
  - Free of the slot being probed while it is occupied: the probe still treats it as occupied and advances.
  - Free on the same edge as a full-pool request in IDLE: alloc_fail is still issued.

## Timing
- Reset values: state=IDLE, occ=0, full=0, alloc_gnt=0, alloc_fail=0, alloc_idx=0, probe_cnt=0, ptr=0.
- Reset mid-probe aborts the allocation. No gnt is issued, and every slot becomes free.
- Let edge E be the one that samples alloc_req in IDLE.
- Grant latency: alloc_gnt is high in the cycle after edge E+1+k, where k is the number of occupied slots probed. With k=0, gnt comes 2 cycles after req is sampled.
- Fail latency: alloc_fail is high in the cycle after edge E (1 cycle).
- A grant's effect on occ is visible in the same cycle that alloc_gnt is high.
- A release becomes visible on occ and full in the cycle after free_vld.
- Throughput is at most one allocation every 2 cycles; release throughput is one per cycle.

## Configuration
- RAND_ALLOC_STATS_EN defined:
  - probe_cnt counts PROBE cycles that found an occupied slot.
  - It is 16-bit, saturates at 0xFFFF, and is cleared only by rst.
- RAND_ALLOC_STATS_EN undefined:
  - probe_cnt is tied to 0 and no counter logic is present.
  - All other behaviour is identical.

## Test plan
- Empty pool, BS=16, rnd=5, alloc_req for one cycle:
  - alloc_gnt appears 2 cycles later with alloc_idx=5.
  - occ=0x0020.
- occ preloaded to 0x00E0 (slots 5,6,7 allocated), rnd=5:
  - gnt after 5 cycles, alloc_idx=8, occ=0x01E0.
  - probe_cnt=3 with the macro defined, 0 without it.
- Wrap-around, occ=0x7FFF, rnd=15:
  - alloc_idx=15 after 2 cycles.
  - Then free slot 3 and request with rnd=15: alloc_idx=3 after 6 cycles (probes 15,0,1,2 are occupied; slot 3 is free), wrapping 15→0.
- Full pool, occ=0xFFFF, request:
  - alloc_fail pulses 1 cycle later, occ is unchanged, no gnt.
  - Same stimulus with free_vld of slot 2 on the request edge: still fail, and occ=0xFFFB afterwards.
- Same-edge conflicts:
  - Free of slot 9 on the edge that grants slot 9: occ[9]=1.
  - Free of a slot that is already free: occ is unchanged.
- rst asserted mid-PROBE with occ=0x00FF: all outputs return to their reset values immediately, no gnt ever appears, and the next request with rnd=0 is granted slot 0.
